// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry add/subtract, one CHUNK-bit slice per stage
// Valid/ready handshake with global stall; carry and operand skew registered per stage.
module rca_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_n [STAGES];
  logic [WIDTH-1:0] b_n [STAGES];
  logic [WIDTH-1:0] s_n [STAGES];
  logic             c_n [STAGES];
  logic             v_n [STAGES];

  logic [WIDTH-1:0] b_eff;
  logic [CHUNK:0]   slice;
  logic             adv;

  // The whole pipe moves as one: any stall at the output freezes every stage.
  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_n[k] = '0;
      b_n[k] = '0;
      s_n[k] = '0;
      c_n[k] = 1'b0;
      v_n[k] = 1'b0;
    end
    slice = '0;

    slice  = {1'b0, a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]} + {{CHUNK{1'b0}}, ci ^ sub};
    a_n[0] = a;
    b_n[0] = b_eff;
    s_n[0][CHUNK-1:0] = slice[CHUNK-1:0];
    c_n[0] = slice[CHUNK];
    v_n[0] = in_valid;

    for (int k = 1; k < STAGES; k++) begin
      slice  = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]} + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_q[k-1]};
      a_n[k] = a_q[k-1];
      b_n[k] = b_q[k-1];
      s_n[k] = s_q[k-1];
      s_n[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      c_n[k] = slice[CHUNK];
      v_n[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
        v_q[k] <= v_n[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
               (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule
